// File: rtl/sd_resp_pkg.sv
// Shared types and constants for the SD sector-handshake responder.
package sd_resp_pkg;

   typedef enum logic [2:0] {
      IDLE,
      DELAY,
      RD_FETCH,
      RD_STROBE,
      WR_SETUP,
      DONE
   } state_e;

   localparam int SECTOR_BYTES = 512;
   localparam int BUFF_LAT     = 2;
   localparam int IDX_W        = 9;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SECTOR_BYTES - 1);

endpackage

// File: rtl/sd_sector_responder.sv
// Target side of the core's SD sector handshake: serves sector reads/writes
// from a byte-wide image store and announces image mounts.
module sd_sector_responder
   import sd_resp_pkg::*;
#(
   parameter int IMG_SECTORS = 16,
   parameter int ADDR_W      = $clog2(IMG_SECTORS) + 9,
   parameter int ACK_DELAY   = 4
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic [31:0]       sd_lba,
   input  logic              sd_rd,
   input  logic              sd_wr,
   output logic              sd_ack,
   output logic [8:0]        sd_buff_addr,
   output logic [7:0]        sd_buff_dout,
   output logic              sd_buff_wr,
   input  logic [7:0]        sd_buff_din,
   input  logic              mount,
   input  logic              img_present,
   output logic              img_mounted,
   output logic [31:0]       img_size,
   output logic [ADDR_W-1:0] st_addr,
   output logic              st_rd,
   output logic              st_wr,
   output logic [7:0]        st_wdata,
   input  logic [7:0]        st_rdata,
   input  logic              st_ack,
   output logic              err
);

   localparam int LBA_W = ADDR_W - IDX_W;
   localparam int CNT_W = (ACK_DELAY > 1) ? $clog2(ACK_DELAY) : 1;
   localparam int PH_W  = $clog2(BUFF_LAT + 1);
   localparam logic [31:0] IMG_BYTES = 32'(IMG_SECTORS * SECTOR_BYTES);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [PH_W-1:0]   phase_q, phase_d;
   logic [LBA_W-1:0]  lba_q, lba_d;
   logic              is_rd_q, is_rd_d;
   logic              in_range_q, in_range_d;
   logic              mount_pend_q, mount_pend_d;
   logic              present_q, present_d;

   logic              sd_ack_q, sd_ack_d;
   logic [8:0]        sd_buff_addr_q, sd_buff_addr_d;
   logic [7:0]        sd_buff_dout_q, sd_buff_dout_d;
   logic              sd_buff_wr_q, sd_buff_wr_d;
   logic              img_mounted_q, img_mounted_d;
   logic [31:0]       img_size_q, img_size_d;
   logic [ADDR_W-1:0] st_addr_q, st_addr_d;
   logic              st_rd_q, st_rd_d;
   logic              st_wr_q, st_wr_d;
   logic [7:0]        st_wdata_q, st_wdata_d;
   logic              err_q, err_d;

   always_comb begin
      // NOTE: every variable gets a default before the case so no path infers a latch.
      state_d        = state_q;
      cnt_d          = cnt_q;
      idx_d          = idx_q;
      phase_d        = phase_q;
      lba_d          = lba_q;
      is_rd_d        = is_rd_q;
      in_range_d     = in_range_q;
      mount_pend_d   = mount_pend_q | mount;
      present_d      = mount ? img_present : present_q;
      sd_ack_d       = sd_ack_q;
      sd_buff_addr_d = sd_buff_addr_q;
      sd_buff_dout_d = sd_buff_dout_q;
      sd_buff_wr_d   = 1'b0;
      img_mounted_d  = 1'b0;
      img_size_d     = img_size_q;
      st_addr_d      = st_addr_q;
      st_rd_d        = st_rd_q;
      st_wr_d        = st_wr_q;
      st_wdata_d     = st_wdata_q;
      err_d          = 1'b0;

      case (state_q)
         IDLE: begin
            // A pending mount is announced before any request is accepted.
            if (mount_pend_d) begin
               img_mounted_d = 1'b1;
               img_size_d    = present_d ? IMG_BYTES : 32'd0;
               mount_pend_d  = 1'b0;
            end else if (sd_rd || sd_wr) begin
               state_d    = DELAY;
               cnt_d      = '0;
               lba_d      = sd_lba[LBA_W-1:0];
               is_rd_d    = sd_rd;
               in_range_d = (sd_lba < 32'(IMG_SECTORS));
               err_d      = !(sd_lba < 32'(IMG_SECTORS));
            end
         end

         DELAY: begin
            if (cnt_q == CNT_W'(ACK_DELAY - 1)) begin
               sd_ack_d = 1'b1;
               idx_d    = '0;
               if (is_rd_q) begin
                  state_d   = RD_FETCH;
                  st_rd_d   = in_range_q;
                  st_addr_d = {lba_q, {IDX_W{1'b0}}};
               end else begin
                  state_d        = WR_SETUP;
                  sd_buff_addr_d = '0;
                  phase_d        = '0;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         RD_FETCH: begin
            if (!in_range_q) begin
               state_d        = RD_STROBE;
               sd_buff_dout_d = 8'h00;
               sd_buff_addr_d = idx_q;
               sd_buff_wr_d   = 1'b1;
            end else if (st_rd_q && st_ack) begin
               state_d        = RD_STROBE;
               st_rd_d        = 1'b0;
               sd_buff_dout_d = st_rdata;
               sd_buff_addr_d = idx_q;
               sd_buff_wr_d   = 1'b1;
            end
         end

         RD_STROBE: begin
            if (idx_q == LAST_IDX) begin
               state_d  = DONE;
               sd_ack_d = 1'b0;
            end else begin
               state_d   = RD_FETCH;
               idx_d     = idx_q + 1'b1;
               st_rd_d   = in_range_q;
               st_addr_d = {lba_q, idx_q + 1'b1};
            end
         end

         WR_SETUP: begin
            // Core buffer RAM is registered: din follows addr by BUFF_LAT edges.
            if (phase_q < PH_W'(BUFF_LAT - 1)) begin
               phase_d = phase_q + 1'b1;
            end else if (phase_q == PH_W'(BUFF_LAT - 1)) begin
               phase_d    = PH_W'(BUFF_LAT);
               st_wdata_d = sd_buff_din;
               st_wr_d    = in_range_q;
               st_addr_d  = {lba_q, idx_q};
            end else if (!st_wr_q || st_ack) begin
               st_wr_d = 1'b0;
               if (idx_q == LAST_IDX) begin
                  state_d  = DONE;
                  sd_ack_d = 1'b0;
               end else begin
                  idx_d          = idx_q + 1'b1;
                  sd_buff_addr_d = idx_q + 1'b1;
                  phase_d        = '0;
               end
            end
         end

         DONE: state_d = IDLE;

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_sys) begin
      // NOTE: reset is synchronous; state and outputs update only with <= on the clock edge.
      if (reset) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         idx_q          <= '0;
         phase_q        <= '0;
         lba_q          <= '0;
         is_rd_q        <= 1'b0;
         in_range_q     <= 1'b0;
         mount_pend_q   <= 1'b0;
         present_q      <= 1'b0;
         sd_ack_q       <= 1'b0;
         sd_buff_addr_q <= '0;
         sd_buff_dout_q <= '0;
         sd_buff_wr_q   <= 1'b0;
         img_mounted_q  <= 1'b0;
         img_size_q     <= '0;
         st_addr_q      <= '0;
         st_rd_q        <= 1'b0;
         st_wr_q        <= 1'b0;
         st_wdata_q     <= '0;
         err_q          <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         idx_q          <= idx_d;
         phase_q        <= phase_d;
         lba_q          <= lba_d;
         is_rd_q        <= is_rd_d;
         in_range_q     <= in_range_d;
         mount_pend_q   <= mount_pend_d;
         present_q      <= present_d;
         sd_ack_q       <= sd_ack_d;
         sd_buff_addr_q <= sd_buff_addr_d;
         sd_buff_dout_q <= sd_buff_dout_d;
         sd_buff_wr_q   <= sd_buff_wr_d;
         img_mounted_q  <= img_mounted_d;
         img_size_q     <= img_size_d;
         st_addr_q      <= st_addr_d;
         st_rd_q        <= st_rd_d;
         st_wr_q        <= st_wr_d;
         st_wdata_q     <= st_wdata_d;
         err_q          <= err_d;
      end
   end

   assign sd_ack       = sd_ack_q;
   assign sd_buff_addr = sd_buff_addr_q;
   assign sd_buff_dout = sd_buff_dout_q;
   assign sd_buff_wr   = sd_buff_wr_q;
   assign img_mounted  = img_mounted_q;
   assign img_size     = img_size_q;
   assign st_addr      = st_addr_q;
   assign st_rd        = st_rd_q;
   assign st_wr        = st_wr_q;
   assign st_wdata     = st_wdata_q;
   assign err          = err_q;

endmodule

// File: tb/tb_sd_sector_responder.sv
// Randomised bench for sd_sector_responder: behavioural store, core buffer
// and image reference model, with a save-style initiator.
module tb_sd_sector_responder;

   localparam int IMG_SECTORS = 16;
   localparam int ADDR_W      = 13;
   localparam int ACK_DELAY   = 4;
   localparam int IMG_BYTES   = IMG_SECTORS * 512;

   logic              clk_sys = 1'b0;
   logic              reset;
   logic [31:0]       sd_lba;
   logic              sd_rd, sd_wr;
   logic              sd_ack;
   logic [8:0]        sd_buff_addr;
   logic [7:0]        sd_buff_dout;
   logic              sd_buff_wr;
   logic [7:0]        sd_buff_din;
   logic              mount, img_present;
   logic              img_mounted;
   logic [31:0]       img_size;
   logic [ADDR_W-1:0] st_addr;
   logic              st_rd, st_wr;
   logic [7:0]        st_wdata;
   logic [7:0]        st_rdata;
   logic              st_ack;
   logic              err;

   always #5 clk_sys = ~clk_sys;

   sd_sector_responder #(
      .IMG_SECTORS(IMG_SECTORS),
      .ADDR_W     (ADDR_W),
      .ACK_DELAY  (ACK_DELAY)
   ) dut (
      .clk_sys     (clk_sys),
      .reset       (reset),
      .sd_lba      (sd_lba),
      .sd_rd       (sd_rd),
      .sd_wr       (sd_wr),
      .sd_ack      (sd_ack),
      .sd_buff_addr(sd_buff_addr),
      .sd_buff_dout(sd_buff_dout),
      .sd_buff_wr  (sd_buff_wr),
      .sd_buff_din (sd_buff_din),
      .mount       (mount),
      .img_present (img_present),
      .img_mounted (img_mounted),
      .img_size    (img_size),
      .st_addr     (st_addr),
      .st_rd       (st_rd),
      .st_wr       (st_wr),
      .st_wdata    (st_wdata),
      .st_rdata    (st_rdata),
      .st_ack      (st_ack),
      .err         (err)
   );

   int vectors = 0;
   int miscompares = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Image store (DUT-facing memory) and the reference image the bench expects.
   logic [7:0] mem     [IMG_BYTES];
   logic [7:0] ref_img [IMG_BYTES];
   logic [7:0] core_buf[512];

   // Core-side sector buffer: 1-cycle registered read.
   always @(posedge clk_sys) sd_buff_din <= core_buf[sd_buff_addr];

   // Behavioural store: acknowledges each op after a random latency in [lat_lo, lat_hi].
   int lat_lo = 1, lat_hi = 1;
   bit store_busy = 1'b0;
   bit op_rd;
   int wait_n;
   logic [ADDR_W-1:0] op_addr;
   logic [7:0] op_wdata;

   always @(negedge clk_sys) begin
      if (st_ack) begin
         st_ack = 1'b0;
      end else begin
         if (!store_busy && (st_rd || st_wr)) begin
            store_busy = 1'b1;
            wait_n     = $urandom_range(lat_hi, lat_lo) - 1;
            op_rd      = st_rd;
            op_addr    = st_addr;
            op_wdata   = st_wdata;
         end
         if (store_busy) begin
            if (wait_n == 0) begin
               if (op_rd) st_rdata = mem[op_addr];
               else       mem[op_addr] = op_wdata;
               st_ack     = 1'b1;
               store_busy = 1'b0;
            end else begin
               wait_n--;
            end
         end
      end
   end

   // Passive monitor of the DUT outputs.
   logic [8:0] cap_addr[$];
   logic [7:0] cap_data[$];
   int st_rd_cyc = 0, st_wr_cyc = 0, both_cyc = 0, bad_wr = 0, err_cnt = 0, ack_rises = 0;
   bit ack_prev = 1'b0;

   always @(negedge clk_sys) begin
      if (sd_buff_wr) begin
         cap_addr.push_back(sd_buff_addr);
         cap_data.push_back(sd_buff_dout);
         if (!sd_ack) bad_wr++;
      end
      if (st_rd) st_rd_cyc++;
      if (st_wr) st_wr_cyc++;
      if (st_rd && st_wr) both_cyc++;
      if (err) err_cnt++;
      if (sd_ack && !ack_prev) ack_rises++;
      ack_prev = sd_ack;
   end

   function automatic logic [7:0] exp_rd(input logic [31:0] lba, input int i);
      if (lba < IMG_SECTORS) return ref_img[int'(lba) * 512 + i];
      return 8'h00;
   endfunction

   task automatic do_mount(input bit present);
      int pulses = 0;
      mount       = 1'b1;
      img_present = present;
      repeat (4) begin
         @(negedge clk_sys);
         mount = 1'b0;
         if (img_mounted) pulses++;
      end
      check("mount_pulse", pulses, 1);
      check("mount_size", img_size, present ? IMG_BYTES : 0);
   endtask

   // One initiator transaction; called at a negedge with the DUT idle.
   task automatic do_xfer(input logic [31:0] lba, input bit rd, input bit wr,
                          input bit mount_mid, input bit mount_req);
      int n, mnt, rd0, wr0, err0, base;
      bit in_rng;
      in_rng = (lba < IMG_SECTORS);
      rd0 = st_rd_cyc; wr0 = st_wr_cyc; err0 = err_cnt;
      cap_addr.delete();
      cap_data.delete();
      sd_lba = lba; sd_rd = rd; sd_wr = wr;
      if (mount_req) begin mount = 1'b1; img_present = 1'b1; end
      n = 0; mnt = 0;
      do begin
         @(negedge clk_sys);
         n++;
         mount = 1'b0;
         if (img_mounted) mnt++;
      end while (!sd_ack && n < 200);
      check("ack_rise", sd_ack, 1);
      check("ack_delay", n, ACK_DELAY + 1 + (mount_req ? 1 : 0));
      if (mount_req) begin
         check("mount_first", mnt, 1);
         check("mount_first_size", img_size, IMG_BYTES);
      end
      sd_rd = 1'b0; sd_wr = 1'b0;
      if (mount_mid) begin
         mount = 1'b1; img_present = 1'b0;
         @(negedge clk_sys);
         mount = 1'b0;
      end
      n = 0; mnt = 0;
      while (sd_ack && n < 20000) begin
         @(negedge clk_sys);
         n++;
         if (img_mounted) mnt++;
      end
      check("ack_fall", sd_ack, 0);
      if (mount_mid) begin
         check("mount_busy", mnt, 0);
         mnt = 0;
         repeat (4) begin
            @(negedge clk_sys);
            if (img_mounted) begin
               mnt++;
               check("mount_ack_low", sd_ack, 0);
            end
         end
         check("mount_after_done", mnt, 1);
         check("mount_absent_size", img_size, 0);
      end
      check("err_pulse", err_cnt - err0, in_rng ? 0 : 1);
      if (rd) begin
         check("strobe_count", cap_addr.size(), 512);
         for (int i = 0; i < 512 && i < cap_addr.size(); i++) begin
            check("rd_addr", cap_addr[i], i);
            check("rd_data", cap_data[i], exp_rd(lba, i));
         end
         if (!in_rng) check("oor_no_st_rd", st_rd_cyc - rd0, 0);
      end else begin
         check("wr_no_strobe", cap_addr.size(), 0);
         if (in_rng) begin
            base = int'(lba) * 512;
            for (int i = 0; i < 512; i++) begin
               ref_img[base + i] = core_buf[i];
               check("wr_data", mem[base + i], core_buf[i]);
            end
         end else begin
            check("oor_no_st_wr", st_wr_cyc - wr0, 0);
         end
      end
      repeat (2) @(negedge clk_sys);
   endtask

   initial begin
      int n, bad, rises0;
      for (int a = 0; a < IMG_BYTES; a++) begin
         mem[a]     = 8'(a) ^ 8'h5A;
         ref_img[a] = 8'(a) ^ 8'h5A;
      end
      for (int i = 0; i < 512; i++) core_buf[i] = 8'h00;
      reset = 1'b1; sd_lba = '0; sd_rd = 1'b0; sd_wr = 1'b0;
      mount = 1'b0; img_present = 1'b0; st_rdata = '0; st_ack = 1'b0;
      repeat (3) @(negedge clk_sys);
      check("rst_sd_ack", sd_ack, 0);
      check("rst_buff_wr", sd_buff_wr, 0);
      check("rst_st_rd", st_rd, 0);
      check("rst_st_wr", st_wr, 0);
      check("rst_img_mounted", img_mounted, 0);
      check("rst_img_size", img_size, 0);
      check("rst_err", err, 0);
      reset = 1'b0;
      @(negedge clk_sys);

      do_mount(1'b1);
      do_mount(1'b0);

      do_xfer(3, 1'b1, 1'b0, 1'b0, 1'b0);
      do_xfer(20, 1'b1, 1'b0, 1'b0, 1'b0);
      do_xfer(5, 1'b1, 1'b1, 1'b0, 1'b0);
      do_xfer(7, 1'b1, 1'b0, 1'b1, 1'b0);
      do_xfer(2, 1'b1, 1'b0, 1'b0, 1'b1);

      // Reset in the middle of a read, then a clean read of LBA 0.
      sd_lba = 1; sd_rd = 1'b1;
      n = 0;
      do begin @(negedge clk_sys); n++; end while (!sd_ack && n < 200);
      sd_rd = 1'b0;
      check("mid_rst_ack_rise", sd_ack, 1);
      cap_addr.delete(); cap_data.delete();
      n = 0;
      while (cap_addr.size() < 100 && n < 5000) begin @(negedge clk_sys); n++; end
      check("mid_rst_reached", cap_addr.size() >= 100, 1);
      reset = 1'b1;
      @(negedge clk_sys);
      check("mid_rst_sd_ack", sd_ack, 0);
      check("mid_rst_st_rd", st_rd, 0);
      reset = 1'b0;
      @(negedge clk_sys);
      do_xfer(0, 1'b1, 1'b0, 1'b0, 1'b0);

      for (int i = 0; i < 512; i++) core_buf[i] = ~8'(i);
      do_xfer(15, 1'b0, 1'b1, 1'b0, 1'b0);
      do_xfer(20, 1'b0, 1'b1, 1'b0, 1'b0);

      // Full save of every sector with random data and random store latency.
      lat_lo = 1; lat_hi = 7;
      rises0 = ack_rises;
      for (int s = 0; s < IMG_SECTORS; s++) begin
         for (int i = 0; i < 512; i++) core_buf[i] = 8'($urandom);
         do_xfer(s, 1'b0, 1'b1, 1'b0, 1'b0);
      end
      check("save_ack_pulses", ack_rises - rises0, IMG_SECTORS);
      bad = 0;
      for (int a = 0; a < IMG_BYTES; a++) if (mem[a] !== ref_img[a]) bad++;
      check("save_image", bad, 0);
      do_xfer(32'($urandom_range(IMG_SECTORS - 1, 0)), 1'b1, 1'b0, 1'b0, 1'b0);

      check("st_rd_wr_overlap", both_cyc, 0);
      check("buff_wr_without_ack", bad_wr, 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #3ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/sd_sector_responder.md
Name: sd_sector_responder

Overview:
- Target end of the core's SD sector handshake (sd_lba/sd_rd/sd_wr/sd_ack/sd_buff_*), which the backup-RAM save/load logic uses as initiator.
- Answers sector reads and writes from a byte-wide backing store and announces image mounts (img_mounted/img_size).
- Lets the save-RAM path run standalone and in simulation without the host-side firmware.
- Sits between the core's backup-RAM engine and a BRAM/SDRAM image store.

Parameters:
- IMG_SECTORS, 16: image capacity in 512-byte sectors.
- ADDR_W, $clog2(IMG_SECTORS)+9: byte address width of the store.
- ACK_DELAY, 4: cycles from request latch to sd_ack rise; models host latency. Must be ≥1.

Ports:
- clk_sys  in  1  system clock
- reset  in  1  synchronous, active-high
- sd_lba  in  32  sector number
- sd_rd  in  1  read request (level)
- sd_wr  in  1  write request (level)
- sd_ack  out  1  transfer in progress
- sd_buff_addr  out  9  byte index within sector
- sd_buff_dout  out  8  read data to core
- sd_buff_wr  out  1  one-cycle strobe, sd_buff_dout valid
- sd_buff_din  in  8  write data from core buffer; 1-cycle registered RAM
- mount  in  1  pulse: announce image
- img_present  in  1  image exists at mount time
- img_mounted  out  1  one-cycle mount pulse
- img_size  out  32  image size in bytes
- st_addr  out  ADDR_W  store byte address
- st_rd  out  1  store read request
- st_wr  out  1  store write request
- st_wdata  out  8  store write data
- st_rdata  in  8  store read data, valid with st_ack
- st_ack  in  1  store completion, one cycle; any latency ≥1
- err  out  1  one-cycle pulse on out-of-range LBA

Behaviour:
Reset:
- All outputs 0; state IDLE.
- Reset mid-transfer: sd_ack, st_rd and st_wr are 0 on the cycle after the reset edge. The outstanding store op is abandoned and st_ack is ignored until the next request.

States and transitions:
- IDLE → DELAY on sd_rd|sd_wr.
  - Latch sd_lba and direction. Read has priority if both are high.
  - Compute in_range = (sd_lba < IMG_SECTORS). If !in_range, pulse err.
- DELAY: count ACK_DELAY cycles, then raise sd_ack and set byte index i=0.
  - Go to RD_FETCH if read, WR_SETUP if write.
- Requests are level signals; the initiator drops them after sd_ack rises. The latched copy is authoritative, and request changes during a transfer are ignored.
- RD_FETCH:
  - If in_range: st_addr={lba[ADDR_W-10:0],i}, st_rd=1 until st_ack, capture st_rdata.
  - Else: data=8'h00 with no store access.
  - Then go to RD_STROBE.
- RD_STROBE: sd_buff_addr=i, sd_buff_dout=data, sd_buff_wr=1 for exactly one cycle.
  - If i==511 go to DONE, else i+1 and back to RD_FETCH.
- WR_SETUP: sd_buff_addr=i; wait 2 cycles for RAM latency, then capture sd_buff_din.
  - If in_range: st_wr=1 with st_addr/st_wdata until st_ack.
  - If i==511 go to DONE, else i+1 and stay in WR_SETUP.
- DONE: drop sd_ack on this cycle. Stay one cycle with sd_ack=0, then IDLE.
  - This gives a guaranteed ≥1-cycle low gap for the initiator's falling-edge detect.

Output rules:
- sd_buff_wr is never high while sd_ack=0.
- sd_buff_addr holds its value between strobes.
- i is 9-bit and never wraps within a transfer.
- st_rd and st_wr are never high together. Each is held until st_ack; st_ack while neither is high is ignored.

Mount:
- A mount pulse sets pending. When in IDLE (deferred while busy), pulse img_mounted one cycle.
- img_size = img_present ? IMG_SECTORS*512 : 0, latched with the pulse and held until the next mount.
- Mount and request arriving in the same IDLE cycle: mount is pulsed first, then the request is accepted the next cycle.

Latency:
- Read: ACK_DELAY + 512×(store latency+2) + 1 cycles, request to sd_ack fall.

Decomposition:
- Package sd_resp_pkg:
  - state enum {IDLE,DELAY,RD_FETCH,RD_STROBE,WR_SETUP,DONE}
  - SECTOR_BYTES=512, BUFF_LAT=2
- Single module; no natural sub-module. The ACK_DELAY counter is inline.

Test Plan:
- Mount: IMG_SECTORS=16, img_present=1, mount pulse → img_mounted high 1 cycle, img_size=8192. With img_present=0 → img_size=0.
- Read LBA 3 from store preloaded with byte[a]=a[7:0]^8'h5A, 1-cycle st_ack:
  - sd_ack rises ACK_DELAY cycles after latch.
  - Exactly 512 sd_buff_wr strobes, addr 0..511, data=(3*512+i)[7:0]^5A.
  - sd_ack falls after the last strobe.
- Write LBA 15 with core buffer[i]=~i[7:0] → store[7680+i]=~i for all 512 bytes; no sd_buff_wr pulses.
- Full save loop of 16 sectors driven by a save-style initiator (drop req on ack rise, re-issue on ack fall):
  - 16 sd_ack pulses, all 8192 bytes correct.
  - Random store latency 1–7 cycles.
- LBA 20 read → err pulse, 512 strobes of 8'h00, st_rd never asserted. LBA 20 write → no st_wr.
- Corner cases:
  - sd_rd&sd_wr together → read performed.
  - Reset at read byte 100 → sd_ack=0 and st_rd=0 next cycle; a following LBA 0 read completes correctly.
  - Mount during a transfer → img_mounted pulses only after DONE→IDLE.
